// File: rtl/traffic_pkg.sv
// Shared traffic-controller definitions: light encodings, emergency detector
// state encoding and default detector timing.
package traffic_pkg;

  typedef logic [1:0] light_t;
  localparam light_t GREEN   = 2'b00;
  localparam light_t YELLOW  = 2'b01;
  localparam light_t ALLSTOP = 2'b10;
  localparam light_t RED     = 2'b11;

  typedef logic [2:0] det_state_t;
  localparam det_state_t DET_IDLE     = 3'd0;
  localparam det_state_t DET_QUALIFY  = 3'd1;
  localparam det_state_t DET_ACTIVE   = 3'd2;
  localparam det_state_t DET_RELEASE  = 3'd3;
  localparam det_state_t DET_COOLDOWN = 3'd4;

  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_MIN_HOLD = 8;
  localparam int DEF_RELEASE  = 3;
  localparam int DEF_MAX_HOLD = 40;
  localparam int DEF_COOLDOWN = 10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs (sensors, buttons).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/emergency_detector.sv
// Turns the raw emergency-vehicle sensor into a debounced, duration-bounded
// level request for the light controllers, followed by a cooldown.
module emergency_detector
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int RELEASE  = DEF_RELEASE,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int COOLDOWN = DEF_COOLDOWN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  input  logic       clear_count,
  output logic       emergency,
  output logic       timeout,
  output logic [7:0] event_count,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN - 1);

  logic             s;
  det_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] hold_cnt, hold_d;
  logic             qualified, tmo_d;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sensor_in),
    .q   (s)
  );

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hold_d    = hold_cnt;
    qualified = 1'b0;
    tmo_d     = 1'b0;
    case (state)
      DET_IDLE: begin
        if (s) begin
          state_d = DET_QUALIFY;
          cnt_d   = CNT_W'(1);
        end
      end
      DET_QUALIFY: begin
        if (!s) begin
          state_d = DET_IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d   = DET_ACTIVE;
          hold_d    = '0;
          qualified = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DET_ACTIVE: begin
        hold_d = hold_cnt + 1'b1;
        if (hold_cnt == MAX_LAST) begin
          state_d = DET_COOLDOWN;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else if (!s && hold_cnt >= MIN_LAST) begin
          state_d = DET_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end
      // Timeout outranks both re-activation and a completed release.
      DET_RELEASE: begin
        hold_d = hold_cnt + 1'b1;
        if (hold_cnt == MAX_LAST) begin
          state_d = DET_COOLDOWN;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else if (s) begin
          state_d = DET_ACTIVE;
        end else if (cnt == REL_LAST) begin
          state_d = DET_COOLDOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DET_COOLDOWN: begin
        if (cnt == CD_LAST) begin
          state_d = DET_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = DET_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DET_IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      emergency   <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      event_count <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hold_cnt  <= hold_d;
      emergency <= (state_d == DET_ACTIVE) || (state_d == DET_RELEASE);
      timeout   <= tmo_d;
      busy      <= (state_d != DET_IDLE);
      if (clear_count)
        event_count <= '0;
      else if (qualified && event_count != 8'hFF)
        event_count <= event_count + 1'b1;
    end
  end

endmodule

// File: doc/emergency_detector.md
Name: emergency_detector

Overview:
- Conditions the raw emergency-vehicle sensor (siren/strobe detector) into the clean, level `emergency` request consumed by the EW and NS traffic-light controllers.
- Synchronises the asynchronous sensor and debounces it.
- Enforces minimum and maximum request durations, then a cooldown, so the light controllers never see chatter or a stuck request.
- Sits directly upstream of the light controllers' `emergency` input.

Parameters:
- CNT_W, 8: width of all internal counters.
- DEBOUNCE, 4: consecutive high samples needed to assert (>=2).
- MIN_HOLD, 8: minimum ACTIVE cycles before sensor-low is honoured (>=1).
- RELEASE, 3: consecutive low samples needed to release (>=2).
- MAX_HOLD, 40: hard timeout on assertion length (> MIN_HOLD+RELEASE).
- COOLDOWN, 10: cycles after release during which the sensor is ignored (>=1).
- All values must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- sensor_in  in  1  raw asynchronous sensor level.
- clear_count  in  1  synchronous clear of event_count.
- emergency  out  1  registered request to the light controllers.
- timeout  out  1  one-cycle pulse when MAX_HOLD forces release.
- event_count  out  8  saturating count of qualified events.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, while rst=1): sync flops=0, state=IDLE, cnt/hold_cnt=0, emergency=0, timeout=0, event_count=0, busy=0. Reset mid-ACTIVE drops emergency immediately; no cooldown follows.
- Synchroniser: two flops, s = sensor_in delayed 2 clocks. Only s is used below.
- States: IDLE, QUALIFY, ACTIVE, RELEASE, COOLDOWN. emergency=1 exactly in ACTIVE and RELEASE (registered from next state).
- IDLE: s=1 -> QUALIFY, cnt=1. Otherwise stay.
- QUALIFY:
  - s=0 -> IDLE, cnt=0.
  - s=1 and cnt==DEBOUNCE-1 -> ACTIVE, hold_cnt=0, event_count+1 (saturates at 255).
  - Else cnt+1.
- ACTIVE (hold_cnt+1 every cycle, priority order):
  - (1) hold_cnt==MAX_HOLD-1 -> COOLDOWN, timeout pulse, cnt=0.
  - (2) s=0 and hold_cnt>=MIN_HOLD-1 -> RELEASE, cnt=1.
  - (3) Else stay. s=0 before MIN_HOLD is ignored.
- RELEASE (hold_cnt keeps counting, priority order):
  - (1) Timeout exactly as in ACTIVE.
  - (2) s=1 -> ACTIVE, hold_cnt not reset.
  - (3) cnt==RELEASE-1 -> COOLDOWN, cnt=0.
  - (4) Else cnt+1.
- COOLDOWN: s ignored. cnt==COOLDOWN-1 -> IDLE; else cnt+1.
- Latency: first s=1 sample to emergency=1 is DEBOUNCE cycles; sensor_in edge to emergency is 2+DEBOUNCE cycles (6 at defaults).
- Min assertion: MIN_HOLD+RELEASE-1 cycles (10). Max assertion: MAX_HOLD cycles exactly (40).
- Emergency low for exactly COOLDOWN cycles after any release.
- Simultaneous events: timeout beats release and beats re-activation. clear_count beats an increment in the same cycle (result 0).
- Counters never wrap: every compare is equality on a bounded range.

Decomposition:
- Shared package `traffic_pkg`:
  - state encoding typedef for this block (3-bit), alongside the existing light-state constants GREEN=00, YELLOW=01, ALLSTOP=10, RED=11;
  - default timing constants (DEBOUNCE, MIN_HOLD, RELEASE, MAX_HOLD, COOLDOWN).
- One sub-module: `sync2`, a two-flop synchroniser with async active-high reset. It is reused later for pedestrian buttons.

Test Plan:
- Glitch rejection: sensor_in high for 3 cycles, then low -> emergency never asserts; event_count stays 0; busy pulses then returns to 0.
- Clean event: sensor_in high at cycle 0 held for 20 cycles, then low -> emergency rises at cycle 6 and stays high until 3 low samples pass; event_count=1; then 10 cooldown cycles with busy=1.
- Min hold: sensor_in high for exactly 4 synchronised samples, then low -> emergency high for exactly 10 cycles; timeout stays 0.
- Chatter in RELEASE: during RELEASE, s low 2 cycles, high 1, then low -> returns to ACTIVE; hold_cnt continues; release completes only after 3 consecutive lows.
- Timeout: sensor_in held high indefinitely -> emergency high for exactly 40 cycles; timeout=1 for one cycle at the falling edge; low 10 cycles; re-qualifies after DEBOUNCE samples; event_count=2.
- Async reset and saturation:
  - rst pulse mid-ACTIVE, between clock edges -> emergency=0 immediately, state IDLE.
  - 260 qualified events -> event_count holds 255; clear_count -> 0.
